// File: rtl/morse_decode_module.sv
// morse_decode_module: decodes S (short x3) / O (long x3) from an active-low lamp bus; ports clk, rst, pin_in[7:0] in; code_out[1:0], valid_sig, err_sig, busy out
module morse_decode_module #(
  parameter logic [23:0] UNIT = 24'd5_999_999,
  parameter int GAP_END = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pin_in,
  output logic [1:0] code_out,
  output logic       valid_sig,
  output logic       err_sig,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, MARK, GAP, DECIDE, DRAIN} state_t;
  state_t state, state_nxt;
  logic s1, mark;
  logic [23:0] cyc;
  logic [2:0] units, shift, shift_nxt;
  logic [1:0] cnt, cnt_nxt, code_q;
  always_ff @(posedge clk) begin
    s1 <= rst ? 1'b0 : pin_in != 8'hff;
    mark <= rst ? 1'b0 : s1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cyc <= '0;
      units <= '0;
      shift <= '0;
      cnt <= '0;
      code_q <= '0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      cnt <= cnt_nxt;
      code_q <= code_out;
      if (state_nxt != state) begin
        cyc <= '0;
        units <= '0;
      end else if (cyc == UNIT) begin
        cyc <= '0;
        units <= units != 3'd7 ? units + 3'd1 : units;
      end else cyc <= cyc + 24'd1;
    end
  // a mark of 6+ units is stuck even if it drops in that same cycle
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt = cnt;
    valid_sig = 1'b0;
    err_sig = 1'b0;
    code_out = code_q;
    case (state)
      IDLE: begin
        shift_nxt = '0;
        cnt_nxt = '0;
        state_nxt = mark ? MARK : IDLE;
      end
      MARK:
        if (units >= 3'd6) begin
          err_sig = 1'b1;
          state_nxt = DRAIN;
        end else if (!mark && units == 3'd0) state_nxt = cnt == 2'd0 ? IDLE : GAP;
        else if (!mark) begin
          shift_nxt = {shift[1:0], units >= 3'd3};
          cnt_nxt = cnt + 2'd1;
          state_nxt = cnt == 2'd2 ? DECIDE : GAP;
        end
      GAP:
        if (units == 3'(GAP_END)) begin
          err_sig = 1'b1;
          state_nxt = IDLE;
        end else if (mark) state_nxt = MARK;
      DECIDE: begin
        state_nxt = IDLE;
        valid_sig = shift == 3'b000 || shift == 3'b111;
        err_sig = !valid_sig;
        code_out = shift == 3'b000 ? 2'b10 : shift == 3'b111 ? 2'b01 : code_q;
      end
      DRAIN: state_nxt = mark ? DRAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      valid_sig = 1'b0;
      err_sig = 1'b0;
      code_out = code_q;
    end
  end
  assign busy = state != IDLE;
endmodule
